// File: rtl/lsu.sv
// rtl/lsu.sv - load/store unit for a single-port word RAM without byte enables
module lsu #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_req,
    output logic                  o_ready,
    input  logic                  i_we,
    input  logic [1:0]            i_size,
    input  logic                  i_unsigned,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    output logic                  o_done,
    output logic                  o_err,
    output logic [DATA_WIDTH-1:0] o_rdata,
    output logic [ADDR_WIDTH-3:0] o_mem_addr,
    output logic                  o_mem_we,
    output logic [DATA_WIDTH-1:0] o_mem_wdata,
    input  logic [DATA_WIDTH-1:0] i_mem_rdata
);

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;

    typedef enum logic [2:0] {S_IDLE, S_RD, S_CAP, S_WR, S_DONE} state_t;

    state_t                state, state_next;
    logic                  we_q;
    logic [1:0]            size_q;
    logic                  uns_q;
    logic [1:0]            off_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic                  accept;
    logic                  misaligned;
    logic [DATA_WIDTH-1:0] lane_shift;
    logic [DATA_WIDTH-1:0] load_data;
    logic [DATA_WIDTH-1:0] merged;

    assign o_ready = (state == S_IDLE);
    assign accept  = o_ready && i_req;

    always_comb begin
        misaligned = 1'b1;
        case (i_size)
            SZ_B:    misaligned = 1'b0;
            SZ_H:    misaligned = i_addr[0];
            SZ_W:    misaligned = |i_addr[1:0];
            default: misaligned = 1'b1;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) state <= S_IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (i_req) begin
                    if (misaligned)                  state_next = S_DONE;
                    else if (i_we && i_size == SZ_W) state_next = S_WR;
                    else                             state_next = S_RD;
                end
            end
            S_RD:    state_next = S_CAP;
            S_CAP:   state_next = we_q ? S_WR : S_DONE;
            S_WR:    state_next = S_DONE;
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // Little-endian lane select: shifting by offset*8 puts the byte/half at bit 0
    assign lane_shift = i_mem_rdata >> {off_q, 3'b000};

    always_comb begin
        load_data = i_mem_rdata;
        case (size_q)
            SZ_B: load_data = uns_q ? {24'b0, lane_shift[7:0]}
                                    : {{24{lane_shift[7]}}, lane_shift[7:0]};
            SZ_H: load_data = uns_q ? {16'b0, lane_shift[15:0]}
                                    : {{16{lane_shift[15]}}, lane_shift[15:0]};
            default: load_data = i_mem_rdata;
        endcase
    end

    always_comb begin
        merged = i_mem_rdata;
        if (size_q == SZ_B) merged[{off_q, 3'b000} +: 8] = wdata_q[7:0];
        else if (off_q[1])  merged[31:16] = wdata_q[15:0];
        else                merged[15:0]  = wdata_q[15:0];
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            we_q        <= 1'b0;
            size_q      <= 2'b00;
            uns_q       <= 1'b0;
            off_q       <= 2'b00;
            wdata_q     <= '0;
            o_done      <= 1'b0;
            o_err       <= 1'b0;
            o_rdata     <= '0;
            o_mem_addr  <= '0;
            o_mem_we    <= 1'b0;
            o_mem_wdata <= '0;
        end else begin
            o_done   <= (state_next == S_DONE);
            o_mem_we <= (state_next == S_WR);
            if (accept) begin
                we_q       <= i_we;
                size_q     <= i_size;
                uns_q      <= i_unsigned;
                off_q      <= i_addr[1:0];
                wdata_q    <= i_wdata;
                o_mem_addr <= i_addr[ADDR_WIDTH-1:2];
                o_err      <= misaligned;
                o_rdata    <= '0;
                if (i_we && i_size == SZ_W && !misaligned) o_mem_wdata <= i_wdata;
            end
            if (state == S_CAP) begin
                if (we_q) o_mem_wdata <= merged;
                else      o_rdata     <= load_data;
            end
            if (state == S_DONE) begin
                o_err   <= 1'b0;
                o_rdata <= '0;
            end
        end
    end

endmodule
